decode_queue: RTL
=================

// Module: decode_queue
// PURPOSE
//  Parametrised decode stage: buffers fetch packets of FETCH_WIDTH instructions, decodes each at enqueue,
//  exposes up to ISSUE_WIDTH decoded entries per cycle in program order to issue.
//  Sits between IF and ID/issue and decouples fetch bandwidth from issue bandwidth.
//  Successor to the single-instruction combinational decoder.
// PARAMETERS
//  FETCH_WIDTH  2  instructions accepted per packet (>=1)
//  ISSUE_WIDTH  2  decoded entries exposed per cycle (>=1)
//  DEPTH        8  queue entries; power of two, >= FETCH_WIDTH+ISSUE_WIDTH
// PORTS
//  clk        in   1                     clock, rising edge
//  resetn     in   1                     asynchronous active-low reset
//  flush      in   1                     discard all entries and this cycle's input
//  in_valid   in   1                     fetch packet present
//  in_ready   out  1                     free slots >= FETCH_WIDTH; 0 while resetn low
//  in_mask    in   FETCH_WIDTH           lane valid, contiguous from lane 0
//  in_inst    in   FETCH_WIDTH*32        raw instructions, lane i = [32i+31:32i]
//  in_pc      in   FETCH_WIDTH*32        PCs per lane
//  out_valid  out  ISSUE_WIDTH           exposed lanes, contiguous from lane 0
//  out_pc     out  ISSUE_WIDTH*32        PC per output lane
//  out_dec    out  ISSUE_WIDTH*$bits(decoded_t)  decoded fields per output lane
//  out_take   in   $clog2(ISSUE_WIDTH+1) entries consumed this cycle, from lane 0
//  count      out  $clog2(DEPTH+1)       current occupancy
// BEHAVIOUR
//  - Reset: head=tail=count=0, out_valid=0, out_pc/out_dec=0, in_ready=0 until resetn high.
//  - Enqueue iff in_valid & in_ready & ~flush: popcount(in_mask) entries written at tail, in lane order.
//    in_mask=0 -> no-op. Non-contiguous mask is illegal (assertion).
//  - Each entry stores pc + decoded_t, decoded combinationally from in_inst at enqueue (registered storage).
//  - Latency: accepted packet visible on out_* the next cycle.
//  - out_valid[i] = (count > i); out lane i = entry head+i (mod DEPTH).
//  - Dequeue: head += out_take. out_take > popcount(out_valid) is illegal (assertion); RTL clamps.
//  - Simultaneous enq/deq: count_next = count + n_in - n_take. in_ready uses the current count
//    (no credit from same-cycle dequeue).
//  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full when count==DEPTH, empty when 0.
//    Order is preserved across wrap.
//  - flush: priority over enq/deq; next cycle head=tail=count=0, out_valid=0.
//  - Reset mid-operation: immediate clear, same as reset values.
//  - decoded_t fields: ityp, oper, func, imme, rs, rt, rd, sy, bp, ri, er.
//    Same ISA semantics as the current ID decoder (I/R/J typing, immediate extension,
//    link register 31 for jal/bal/jalr).
// CONFIGURATION
//  DQ_DELAY_SLOT_PAIR_EN defined:
//    - A jump/branch entry (IS_OPER_JB, OPER_J, OPER_JR) is never exposed without its delay slot.
//    - If the last exposed lane holds such an entry and its successor is not present in the queue
//      or not in the window, that lane's out_valid=0; the entry is held to a later cycle.
//    - ISSUE_WIDTH<2 is an elaboration error.
//  Undefined: exposure by occupancy only.
// STRUCTURE
//  - Package includes: typedef struct packed decoded_t (uses `W_TYPE/`W_OPER/`W_FUNC/`W_DATA/`W_REGF)
//    and function is_ctrl_xfer(oper).
//  - Sub-module decode_lane: combinational inst[31:0] -> decoded_t.
//    Instantiated FETCH_WIDTH times on the enqueue side.
//  - Queue storage, pointers and the exposure mask live in decode_queue.
// TESTING (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8)
//  1. resetn=0 -> out_valid=0, count=0, in_ready=0; release -> in_ready=1 at next edge.
//  2. Push 0x24080005 (addiu $t0,$zero,5), mask 2'b01, pc 0xBFC00000
//     -> next cycle out_valid=2'b01, rd=8, rs=0, imme=5, oper=OPER_ALUU, func=FUNC_ADD, count=1.
//  3. Four packets mask 2'b11, out_take=0 -> count 2,4,6,8; in_ready=0 only at count 8;
//     a 5th in_valid is not accepted.
//  4. count=6 with head near wrap; push 2'b11 and out_take=2 same cycle
//     -> count stays 6; dequeued PCs strictly increasing across wrap.
//  5. count=5, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; flushed packet never appears.
//  6. Empty queue; push beq (0x10000003), mask 2'b01
//     -> macro on: out_valid=0 until delay slot pushed, then 2'b11. Macro off: out_valid=2'b01 next cycle.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: decoded instruction record, operation and
// function codes, and the control-transfer classifier used for delay-slot pairing.
`ifndef W_TYPE
`define W_TYPE 2
`endif
`ifndef W_OPER
`define W_OPER 4
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_REGF
`define W_REGF 5
`endif

package decode_queue_pkg;

   typedef enum logic [`W_TYPE-1:0] {ITYP_I = 0, ITYP_R = 1, ITYP_J = 2} ityp_e;

   typedef enum logic [`W_OPER-1:0] {
      OPER_NONE = 0, OPER_ALUS = 1, OPER_ALUU = 2, OPER_LOAD = 3,
      OPER_STOR = 4, OPER_JB   = 5, OPER_J    = 6, OPER_JR   = 7
   } oper_e;

   localparam logic [`W_FUNC-1:0] FUNC_NONE = 5'd0,  FUNC_ADD  = 5'd1,  FUNC_SUB  = 5'd2;
   localparam logic [`W_FUNC-1:0] FUNC_AND  = 5'd3,  FUNC_OR   = 5'd4,  FUNC_XOR  = 5'd5;
   localparam logic [`W_FUNC-1:0] FUNC_NOR  = 5'd6,  FUNC_SLT  = 5'd7,  FUNC_SLL  = 5'd8;
   localparam logic [`W_FUNC-1:0] FUNC_SRL  = 5'd9,  FUNC_SRA  = 5'd10, FUNC_LUI  = 5'd11;
   localparam logic [`W_FUNC-1:0] FUNC_BEQ  = 5'd12, FUNC_BNE  = 5'd13, FUNC_BLEZ = 5'd14;
   localparam logic [`W_FUNC-1:0] FUNC_BGTZ = 5'd15, FUNC_BLTZ = 5'd16, FUNC_BGEZ = 5'd17;

   localparam logic [`W_REGF-1:0] REG_LINK = 5'd31;

   typedef struct packed {
      ityp_e               ityp;
      oper_e               oper;
      logic [`W_FUNC-1:0]  func;
      logic [`W_DATA-1:0]  imme;
      logic [`W_REGF-1:0]  rs;
      logic [`W_REGF-1:0]  rt;
      logic [`W_REGF-1:0]  rd;
      logic                sy;
      logic                bp;
      logic                ri;
      logic                er;
   } decoded_t;

   function automatic logic is_ctrl_xfer(input oper_e oper);
      return (oper == OPER_JB) || (oper == OPER_J) || (oper == OPER_JR);
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder: raw 32-bit MIPS-style word to decoded_t.
module decode_lane
   import decode_queue_pkg::*;
(
   input  logic [31:0] i_inst,
   output decoded_t    o_dec
);

   logic [5:0]         w_op;
   logic [5:0]         w_fn;
   logic [`W_DATA-1:0] w_simm;
   logic [`W_DATA-1:0] w_zimm;

   assign w_op   = i_inst[31:26];
   assign w_fn   = i_inst[5:0];
   assign w_simm = {{16{i_inst[15]}}, i_inst[15:0]};
   assign w_zimm = {16'd0, i_inst[15:0]};

   // I-type writes rt by default; R-type, branches and stores override rd.
   always_comb begin
      o_dec      = '0;
      o_dec.ityp = ITYP_I;
      o_dec.rs   = i_inst[25:21];
      o_dec.rt   = i_inst[20:16];
      o_dec.rd   = i_inst[20:16];
      case (w_op)
         6'h00: begin
            o_dec.ityp = ITYP_R;
            o_dec.oper = OPER_ALUS;
            o_dec.rd   = i_inst[15:11];
            case (w_fn)
               6'h00: begin o_dec.func = FUNC_SLL; o_dec.imme = {27'd0, i_inst[10:6]}; end
               6'h02: begin o_dec.func = FUNC_SRL; o_dec.imme = {27'd0, i_inst[10:6]}; end
               6'h03: begin o_dec.func = FUNC_SRA; o_dec.imme = {27'd0, i_inst[10:6]}; end
               6'h08: begin o_dec.oper = OPER_JR; o_dec.rd = '0; end
               6'h09: begin o_dec.oper = OPER_JR; o_dec.rd = REG_LINK; end
               6'h0C: begin
                  o_dec.oper = OPER_NONE; o_dec.sy = 1'b1;
                  o_dec.rs = '0; o_dec.rt = '0; o_dec.rd = '0;
               end
               6'h0D: begin
                  o_dec.oper = OPER_NONE; o_dec.bp = 1'b1;
                  o_dec.rs = '0; o_dec.rt = '0; o_dec.rd = '0;
               end
               6'h20: o_dec.func = FUNC_ADD;
               6'h21: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_ADD; end
               6'h22: o_dec.func = FUNC_SUB;
               6'h23: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_SUB; end
               6'h24: o_dec.func = FUNC_AND;
               6'h25: o_dec.func = FUNC_OR;
               6'h26: o_dec.func = FUNC_XOR;
               6'h27: o_dec.func = FUNC_NOR;
               6'h2A: o_dec.func = FUNC_SLT;
               6'h2B: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_SLT; end
               default: begin o_dec.oper = OPER_NONE; o_dec.ri = 1'b1; end
            endcase
         end
         6'h01: begin
            o_dec.oper = OPER_JB;
            o_dec.imme = w_simm;
            o_dec.rd   = i_inst[20] ? REG_LINK : '0;
            case (i_inst[20:16])
               5'h00, 5'h10: o_dec.func = FUNC_BLTZ;
               5'h01, 5'h11: o_dec.func = FUNC_BGEZ;
               default: begin o_dec.oper = OPER_NONE; o_dec.ri = 1'b1; o_dec.rd = '0; end
            endcase
         end
         6'h02, 6'h03: begin
            o_dec.ityp = ITYP_J;
            o_dec.oper = OPER_J;
            o_dec.imme = {6'd0, i_inst[25:0]};
            o_dec.rs   = '0;
            o_dec.rt   = '0;
            o_dec.rd   = w_op[0] ? REG_LINK : '0;
         end
         6'h04: begin o_dec.oper = OPER_JB; o_dec.func = FUNC_BEQ;  o_dec.imme = w_simm; o_dec.rd = '0; end
         6'h05: begin o_dec.oper = OPER_JB; o_dec.func = FUNC_BNE;  o_dec.imme = w_simm; o_dec.rd = '0; end
         6'h06: begin o_dec.oper = OPER_JB; o_dec.func = FUNC_BLEZ; o_dec.imme = w_simm; o_dec.rd = '0; end
         6'h07: begin o_dec.oper = OPER_JB; o_dec.func = FUNC_BGTZ; o_dec.imme = w_simm; o_dec.rd = '0; end
         6'h08: begin o_dec.oper = OPER_ALUS; o_dec.func = FUNC_ADD; o_dec.imme = w_simm; end
         6'h09: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_ADD; o_dec.imme = w_simm; end
         6'h0A: begin o_dec.oper = OPER_ALUS; o_dec.func = FUNC_SLT; o_dec.imme = w_simm; end
         6'h0B: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_SLT; o_dec.imme = w_simm; end
         6'h0C: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_AND; o_dec.imme = w_zimm; end
         6'h0D: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_OR;  o_dec.imme = w_zimm; end
         6'h0E: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_XOR; o_dec.imme = w_zimm; end
         6'h0F: begin o_dec.oper = OPER_ALUU; o_dec.func = FUNC_LUI; o_dec.imme = {i_inst[15:0], 16'd0}; end
         6'h10: begin
            o_dec.rd = '0;
            if (i_inst[25:0] == 26'h2000018) o_dec.er = 1'b1;
            else                             o_dec.ri = 1'b1;
         end
         // Memory ops carry the access size/sign code (opcode low bits) in func.
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin
            o_dec.oper = OPER_LOAD; o_dec.func = {2'b00, w_op[2:0]}; o_dec.imme = w_simm;
         end
         6'h28, 6'h29, 6'h2B: begin
            o_dec.oper = OPER_STOR; o_dec.func = {2'b00, w_op[2:0]}; o_dec.imme = w_simm; o_dec.rd = '0;
         end
         default: begin o_dec.ri = 1'b1; o_dec.rd = '0; end
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// Decode queue between fetch and issue: decodes fetch packets on entry, exposes up to
// ISSUE_WIDTH entries in order. DQ_DELAY_SLOT_PAIR_EN holds a jump/branch until its delay slot is exposable.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned DEPTH       = 8
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic                                   flush,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [FETCH_WIDTH-1:0]                 in_mask,
   input  logic [FETCH_WIDTH*32-1:0]              in_inst,
   input  logic [FETCH_WIDTH*32-1:0]              in_pc,
   output logic [ISSUE_WIDTH-1:0]                 out_valid,
   output logic [ISSUE_WIDTH*32-1:0]              out_pc,
   output logic [ISSUE_WIDTH*$bits(decoded_t)-1:0] out_dec,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]       out_take,
   output logic [$clog2(DEPTH+1)-1:0]             count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned DW = $bits(decoded_t);

`ifdef DQ_DELAY_SLOT_PAIR_EN
   if (ISSUE_WIDTH < 2) begin : g_iw_check
      $error("decode_queue: delay-slot pairing needs ISSUE_WIDTH >= 2");
   end
`endif

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic          r_rdy;
   logic [31:0]   r_pc  [DEPTH];
   decoded_t      r_dec [DEPTH];

   decoded_t      w_lane_dec [FETCH_WIDTH];
   logic [PW-1:0] w_count;
   logic [PW-1:0] w_n_in;
   logic [PW-1:0] w_n_occ;
   logic [PW-1:0] w_n_vis;
   logic [PW-1:0] w_n_take;
   logic          w_enq;

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
      decode_lane u_decode_lane (
         .i_inst (in_inst[g*32 +: 32]),
         .o_dec  (w_lane_dec[g])
      );
   end

   // Wrap-bit pointers make the difference the occupancy directly.
   assign w_count  = r_tail - r_head;
   assign count    = w_count;
   assign in_ready = r_rdy && (w_count <= PW'(DEPTH - FETCH_WIDTH));
   assign w_enq    = in_valid && in_ready && !flush;

   always_comb begin
      w_n_in = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) w_n_in = w_n_in + PW'(in_mask[i]);
   end

   assign w_n_occ = (w_count < PW'(ISSUE_WIDTH)) ? w_count : PW'(ISSUE_WIDTH);

`ifdef DQ_DELAY_SLOT_PAIR_EN
   logic [PW-1:0] w_last;
   // The last exposed lane never has its successor in the window, so a transfer there waits.
   assign w_last  = r_head + w_n_occ - PW'(1);
   assign w_n_vis = ((w_n_occ != '0) && is_ctrl_xfer(r_dec[w_last[AW-1:0]].oper)) ?
                    (w_n_occ - PW'(1)) : w_n_occ;
`else
   assign w_n_vis = w_n_occ;
`endif

   assign w_n_take = (PW'(out_take) > w_n_vis) ? w_n_vis : PW'(out_take);

   always_comb begin
      out_valid = '0;
      out_pc    = '0;
      out_dec   = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         if (PW'(i) < w_n_vis) begin
            out_valid[i]         = 1'b1;
            out_pc[i*32 +: 32]   = r_pc[AW'(r_head + PW'(i))];
            out_dec[i*DW +: DW]  = r_dec[AW'(r_head + PW'(i))];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head <= '0;
         r_tail <= '0;
         r_rdy  <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (flush) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            r_head <= r_head + w_n_take;
            if (w_enq) r_tail <= r_tail + w_n_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (in_mask[i]) begin
               r_pc[AW'(r_tail + PW'(i))]  <= in_pc[i*32 +: 32];
               r_dec[AW'(r_tail + PW'(i))] <= w_lane_dec[i];
            end
         end
      end
   end

   a_mask_contig: assert property (@(posedge clk) disable iff (!resetn)
      in_valid |-> ((in_mask & (in_mask + 1'b1)) == '0));
   a_take_legal: assert property (@(posedge clk) disable iff (!resetn)
      !flush |-> (PW'(out_take) <= w_n_vis));

endmodule
